prog_timer: RTL

- Parametrised successor to the 8-bit up/down counter: programmable width, terminal value and tick prescaler.
- Adds a parallel load, one-shot or auto-reload modes, and a sticky expiry flag.
- Acts as the general timer/event counter for control blocks that need a timeout or periodic strobe.
- Fully synchronous to one rising clock edge; no falling-edge logic.

---
 rtl/prog_timer.sv | 106 ++++++++++
 1 files changed

// File: rtl/prog_timer.sv
// Programmable up/down timer with tick prescaler, parallel load, one-shot or
// auto-reload operation and a sticky expiry state.
module prog_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  up0_dn1,
  input  logic                  clear,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic [WIDTH-1:0]      term_value,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale_div,
  output logic [WIDTH-1:0]      count,
  output logic                  done,
  output logic                  expired,
  output logic                  running
);

  localparam logic [WIDTH-1:0]      CNT_ONE = WIDTH'(1);
  localparam logic [PRESCALE_W-1:0] PRE_ONE = PRESCALE_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_EXPIRED
  } state_e;

  state_e                  state_q, state_d;
  logic [WIDTH-1:0]        count_q, count_d;
  logic [PRESCALE_W-1:0]   presc_q, presc_d;
  logic                    done_q, done_d;
  logic [WIDTH-1:0]        terminal;
  logic [WIDTH-1:0]        reload_val;
  logic [WIDTH-1:0]        stepped;

  always_comb begin
    terminal   = up0_dn1 ? '0 : term_value;
    reload_val = up0_dn1 ? term_value : '0;
    stepped    = up0_dn1 ? (count_q - CNT_ONE) : (count_q + CNT_ONE);

    state_d = state_q;
    count_d = count_q;
    presc_d = presc_q;
    done_d  = 1'b0;

    if (clear) begin
      count_d = '0;
      presc_d = '0;
      state_d = enable ? ST_RUN : ST_IDLE;
    end else if (load) begin
      count_d = load_value;
      presc_d = '0;
      state_d = enable ? ST_RUN : ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!enable) begin
            state_d = ST_IDLE;
          end else if (presc_q != prescale_div) begin
            presc_d = presc_q + PRE_ONE;
          end else begin
            presc_d = '0;
            // Sitting on the terminal with auto-reload restarts the period silently.
            if ((count_q == terminal) && auto_reload) begin
              count_d = reload_val;
            end else begin
              count_d = stepped;
              if (stepped == terminal) begin
                done_d = 1'b1;
                if (!auto_reload) state_d = ST_EXPIRED;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      count_q <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign count   = count_q;
  assign done    = done_q;
  assign expired = (state_q == ST_EXPIRED);
  assign running = (state_q == ST_RUN);

endmodule
